mips_multicycle_control: RTL and testbench

//  Multi-cycle MIPS main control FSM: decodes opcode and sequences FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mips_multicycle_control_if.sv | 40 ++++
 rtl/mips_multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multi-cycle MIPS control FSM and the datapath.
// Latency: none, this is wiring only; the FSM drives the controls from its state register.
// Backpressure: mem_ready from memory stalls the FSM in FETCH/MEM_RD/MEM_WR.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  // Control side: consumes opcode/mem_ready, drives datapath enables.
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_count
  );

  // Datapath side: the mirror image.
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_count
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and retire counter.
// Latency: Moore outputs from the state register; 3-5 cycles per instruction plus memory waits.
// Backpressure: mem_ready low holds FETCH/MEM_RD/MEM_WR with requests stable. MIPS_ADDI_EN enables addi.
module mips_multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 16
) (
  input logic                         clk,
  input logic                         rst_n,
  mips_multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctl_t             ctl_c, ctl_o;
  logic             rdy;
  logic             retire;

  // With USE_MEM_READY off, memory is assumed to complete every cycle.
  assign rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

  // Next-state, Moore output decode and retire detection.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ctl_c    = '0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = 2'b01;
        if (rdy) begin
          ctl_c.ir_write = 1'b1;
          ctl_c.pc_write = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl_c.alu_src_b = 2'b11;
        // Latch the opcode so later IR changes cannot redirect this instruction.
        opcode_d = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default: begin
            ctl_c.illegal_op = 1'b1;
            state_d          = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = 2'b10;
        state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.i_or_d   = 1'b1;
        if (rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        ctl_c.mem_write = 1'b1;
        ctl_c.i_or_d    = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_op    = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        ctl_c.reg_write = 1'b1;
        ctl_c.reg_dst   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctl_c.alu_src_a     = 1'b1;
        ctl_c.alu_op        = 2'b01;
        ctl_c.pc_write_cond = 1'b1;
        ctl_c.pc_source     = 2'b01;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctl_c.pc_write  = 1'b1;
        ctl_c.pc_source = 2'b10;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MIPS_ADDI_EN
      S_ADDI_EX: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctl_c.reg_write = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`endif
      // Unused codes recover to FETCH with all controls low.
      default: state_d = S_FETCH;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  // State, captured opcode and retire counter; reset wins over any pending retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
    end
  end

  // While reset is held every output, including the counter, reads zero.
  assign ctl_o = rst_n ? ctl_c : '0;

  assign bus.pc_write      = ctl_o.pc_write;
  assign bus.pc_write_cond = ctl_o.pc_write_cond;
  assign bus.i_or_d        = ctl_o.i_or_d;
  assign bus.mem_read      = ctl_o.mem_read;
  assign bus.mem_write     = ctl_o.mem_write;
  assign bus.ir_write      = ctl_o.ir_write;
  assign bus.mem_to_reg    = ctl_o.mem_to_reg;
  assign bus.reg_dst       = ctl_o.reg_dst;
  assign bus.reg_write     = ctl_o.reg_write;
  assign bus.alu_src_a     = ctl_o.alu_src_a;
  assign bus.alu_src_b     = ctl_o.alu_src_b;
  assign bus.alu_op        = ctl_o.alu_op;
  assign bus.pc_source     = ctl_o.pc_source;
  assign bus.illegal_op    = ctl_o.illegal_op;
  assign bus.instr_count   = rst_n ? count_q : '0;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed table-driven bench for mips_multicycle_control.
// Each row: drive inputs, compare the control word and retire count, then clock once.
// Hand-written tail: reset landing on a MEM_WR with mem_ready high must not retire.
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;

  mips_multicycle_control_if #(.CNT_W(16)) ifc ();

  mips_multicycle_control #(.USE_MEM_READY(1'b1), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal_op}
  logic [16:0] act_ctl;
  assign act_ctl = {ifc.pc_write, ifc.pc_write_cond, ifc.i_or_d, ifc.mem_read,
                    ifc.mem_write, ifc.ir_write, ifc.mem_to_reg, ifc.reg_dst,
                    ifc.reg_write, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_op,
                    ifc.pc_source, ifc.illegal_op};

  localparam logic [16:0] C_ZERO     = 17'b0;
  localparam logic [16:0] C_FETCH_RD = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FETCH_WT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DECODE   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DEC_ILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MEM_ADDR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEM_RD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEM_WB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEM_WR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_R_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_R_WB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BRANCH   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JUMP     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
`ifdef MIPS_ADDI_EN
  localparam logic [16:0] C_ADDI_WB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
`endif

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic [16:0] ctl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_total;
  int   n_pass;

  function automatic void add(input logic r, input logic [5:0] op, input logic mr,
                              input logic [16:0] ctl, input logic [15:0] cnt);
    vec_t v;
    v.rst_n = r; v.op = op; v.mr = mr; v.ctl = ctl; v.cnt = cnt;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    ifc.opcode    = 6'h00;
    ifc.mem_ready = 1'b1;

    // reset state
    add(0, 6'h00, 1, C_ZERO,     0);
    // R-type: FETCH, DECODE, R_EXEC, R_WB
    add(1, 6'h00, 1, C_FETCH_RD, 0);
    add(1, 6'h00, 1, C_DECODE,   0);
    add(1, 6'h00, 1, C_R_EXEC,   0);
    add(1, 6'h00, 1, C_R_WB,     0);
    // lw; IR changes to sw after DECODE, memory stalls 3 cycles in MEM_RD
    add(1, 6'h23, 1, C_FETCH_RD, 1);
    add(1, 6'h23, 1, C_DECODE,   1);
    add(1, 6'h2B, 0, C_MEM_ADDR, 1);
    add(1, 6'h2B, 0, C_MEM_RD,   1);
    add(1, 6'h2B, 0, C_MEM_RD,   1);
    add(1, 6'h2B, 0, C_MEM_RD,   1);
    add(1, 6'h2B, 1, C_MEM_RD,   1);
    add(1, 6'h2B, 1, C_MEM_WB,   1);
    // sw with a stalled FETCH and a stalled MEM_WR
    add(1, 6'h2B, 0, C_FETCH_WT, 2);
    add(1, 6'h2B, 1, C_FETCH_RD, 2);
    add(1, 6'h2B, 1, C_DECODE,   2);
    add(1, 6'h2B, 0, C_MEM_ADDR, 2);
    add(1, 6'h2B, 0, C_MEM_WR,   2);
    add(1, 6'h2B, 1, C_MEM_WR,   2);
    // beq
    add(1, 6'h04, 1, C_FETCH_RD, 3);
    add(1, 6'h04, 1, C_DECODE,   3);
    add(1, 6'h04, 1, C_BRANCH,   3);
    // j
    add(1, 6'h02, 1, C_FETCH_RD, 4);
    add(1, 6'h02, 1, C_DECODE,   4);
    add(1, 6'h02, 1, C_JUMP,     4);
    // illegal opcode: one-cycle pulse, no retire
    add(1, 6'h3F, 1, C_FETCH_RD, 5);
    add(1, 6'h3F, 1, C_DEC_ILL,  5);
    add(1, 6'h00, 1, C_FETCH_RD, 5);
    add(1, 6'h00, 1, C_DECODE,   5);
    add(1, 6'h00, 1, C_R_EXEC,   5);
    add(1, 6'h00, 1, C_R_WB,     5);
    // lw interrupted by a 2-cycle reset while stalled in MEM_RD
    add(1, 6'h23, 1, C_FETCH_RD, 6);
    add(1, 6'h23, 1, C_DECODE,   6);
    add(1, 6'h23, 0, C_MEM_ADDR, 6);
    add(1, 6'h23, 0, C_MEM_RD,   6);
    add(0, 6'h23, 0, C_ZERO,     0);
    add(0, 6'h23, 0, C_ZERO,     0);
    add(1, 6'h08, 1, C_FETCH_RD, 0);
    // addi opcode
`ifdef MIPS_ADDI_EN
    add(1, 6'h08, 1, C_DECODE,   0);
    add(1, 6'h08, 1, C_MEM_ADDR, 0);
    add(1, 6'h00, 1, C_ADDI_WB,  0);
    add(1, 6'h00, 1, C_FETCH_RD, 1);
`else
    add(1, 6'h08, 1, C_DEC_ILL,  0);
    add(1, 6'h00, 1, C_FETCH_RD, 0);
    add(1, 6'h00, 1, C_DECODE,   0);
    add(1, 6'h00, 1, C_R_EXEC,   0);
`endif

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      rst_n         = vq[i].rst_n;
      ifc.opcode    = vq[i].op;
      ifc.mem_ready = vq[i].mr;
      #1;
      chk($sformatf("row%0d_ctl", i), 64'(act_ctl), 64'(vq[i].ctl));
      chk($sformatf("row%0d_cnt", i), 64'(ifc.instr_count), 64'(vq[i].cnt));
      @(posedge clk);
      #1;
    end

    // Reset arriving on the very edge a store would complete.
    rst_n = 1'b0;
    ifc.opcode = 6'h2B;
    ifc.mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;   // DECODE
    @(posedge clk); #1;   // MEM_ADDR
    @(posedge clk); #1;   // MEM_WR
    chk("sw_in_mem_wr", 64'(act_ctl), 64'(C_MEM_WR));
    rst_n = 1'b0;
    #1;
    chk("sw_rst_forced_zero", 64'(act_ctl), 64'(C_ZERO));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("sw_rst_no_retire", 64'(ifc.instr_count), 64'(0));
    chk("sw_rst_back_fetch", 64'(act_ctl), 64'(C_FETCH_RD));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
